// File: rtl/synth_voice_pkg.sv
// Shared defaults, FSM encoding and event-kind encoding for the voice allocator.
package synth_voice_pkg;

  localparam int unsigned NUM_VOICES_DEF = 8;
  localparam int unsigned NOTE_WIDTH_DEF = 7;
  localparam int unsigned VEL_WIDTH_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RETRIG = 2'd2,
    ST_COMMIT = 2'd3
  } va_state_e;

  typedef enum logic [1:0] {
    KIND_OFF    = 2'd0,
    KIND_FREE   = 2'd1,
    KIND_RETRIG = 2'd2,
    KIND_STEAL  = 2'd3
  } va_kind_e;

  // Index width for a voice count, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Age ranking of voices: rank 0 is newest, NUM_VOICES-1 is oldest.
// A touch makes the target newest and ages every voice that was younger than it.
module voice_age_tracker
  import synth_voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  localparam int unsigned IDX_W = idx_width(NUM_VOICES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  output logic [IDX_W-1:0] oldest_o
);

  logic [IDX_W-1:0] rank_q [NUM_VOICES];
  logic [IDX_W-1:0] rank_d [NUM_VOICES];
  logic [IDX_W-1:0] old_rank;
  logic [IDX_W-1:0] oldest_q;
  logic [IDX_W-1:0] oldest_d;

  always_comb begin
    old_rank = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (IDX_W'(v) == touch_idx_i) old_rank = rank_q[v];
    end
  end

  always_comb begin
    rank_d = rank_q;
    if (touch_i) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (IDX_W'(v) == touch_idx_i) begin
          rank_d[v] = '0;
        end else if (rank_q[v] < old_rank) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
    end
  end

  // Oldest index is registered alongside the ranks it is derived from.
  always_comb begin
    oldest_d = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (rank_d[v] == IDX_W'(NUM_VOICES - 1)) oldest_d = IDX_W'(v);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        rank_q[v] <= IDX_W'(NUM_VOICES - 1 - v);
      end
      oldest_q <= '0;
    end else begin
      rank_q   <= rank_d;
      oldest_q <= oldest_d;
    end
  end

  assign oldest_o = oldest_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto voice slots with
// retrigger, lowest-free and oldest-steal policies, plus a panic clear.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned NOTE_WIDTH = NOTE_WIDTH_DEF,
  parameter int unsigned VEL_WIDTH  = VEL_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic                             ev_on,
  input  logic [NOTE_WIDTH-1:0]            ev_note,
  input  logic [VEL_WIDTH-1:0]             ev_velocity,
  input  logic                             all_notes_off,
  output logic [NUM_VOICES-1:0]            note_on,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity,
  output logic                             steal_pulse
);

  localparam int unsigned IDX_W = idx_width(NUM_VOICES);

  va_state_e                       state_q, state_d;
  va_kind_e                        kind_q, kind_d;
  logic [IDX_W-1:0]                tgt_q, tgt_d;
  logic                            is_on_q, is_on_d;
  logic [NOTE_WIDTH-1:0]           ev_note_q, ev_note_d;
  logic [VEL_WIDTH-1:0]            ev_vel_q, ev_vel_d;
  logic [NUM_VOICES-1:0]           note_on_q, note_on_d;
  logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note_q, voice_note_d;
  logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_vel_q, voice_vel_d;
  logic                            steal_q, steal_d;
  logic                            ready_q, ready_d;

  logic                            touch;
  logic [IDX_W-1:0]                oldest;
  logic                            retrig_hit, free_hit;
  logic [IDX_W-1:0]                retrig_idx, free_idx;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES)
  ) u_age (
    .clk         (clk),
    .rst_n       (rst_n),
    .touch_i     (touch),
    .touch_idx_i (tgt_q),
    .oldest_o    (oldest)
  );

  // Lowest-index gated voice holding the latched note, and lowest-index free voice.
  always_comb begin
    retrig_hit = 1'b0;
    retrig_idx = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (note_on_q[v] && (voice_note_q[v*NOTE_WIDTH +: NOTE_WIDTH] == ev_note_q)) begin
        retrig_hit = 1'b1;
        retrig_idx = IDX_W'(v);
      end
      if (!note_on_q[v]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(v);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    tgt_d        = tgt_q;
    is_on_d      = is_on_q;
    ev_note_d    = ev_note_q;
    ev_vel_d     = ev_vel_q;
    note_on_d    = note_on_q;
    voice_note_d = voice_note_q;
    voice_vel_d  = voice_vel_q;
    steal_d      = 1'b0;
    touch        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ev_valid) begin
          is_on_d   = ev_on && (ev_velocity != '0);
          ev_note_d = ev_note;
          ev_vel_d  = ev_velocity;
          state_d   = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (!is_on_q) begin
          kind_d  = KIND_OFF;
          state_d = ST_COMMIT;
        end else if (retrig_hit) begin
          kind_d  = KIND_RETRIG;
          tgt_d   = retrig_idx;
          state_d = ST_RETRIG;
        end else if (free_hit) begin
          kind_d  = KIND_FREE;
          tgt_d   = free_idx;
          state_d = ST_COMMIT;
        end else begin
          kind_d  = KIND_STEAL;
          tgt_d   = oldest;
          state_d = ST_RETRIG;
        end
      end
      ST_RETRIG: begin
        // One-cycle gate gap so the envelope sees a fresh attack.
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (IDX_W'(v) == tgt_q) note_on_d[v] = 1'b0;
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (kind_q == KIND_OFF) begin
          for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (note_on_q[v] && (voice_note_q[v*NOTE_WIDTH +: NOTE_WIDTH] == ev_note_q)) begin
              note_on_d[v] = 1'b0;
            end
          end
        end else begin
          for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (IDX_W'(v) == tgt_q) begin
              note_on_d[v]                          = 1'b1;
              voice_note_d[v*NOTE_WIDTH +: NOTE_WIDTH] = ev_note_q;
              voice_vel_d[v*VEL_WIDTH +: VEL_WIDTH]    = ev_vel_q;
            end
          end
          touch   = 1'b1;
          steal_d = (kind_q == KIND_STEAL);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Panic wins over any pending or arriving event; ranks stay put.
    if (all_notes_off) begin
      note_on_d    = '0;
      voice_note_d = voice_note_q;
      voice_vel_d  = voice_vel_q;
      steal_d      = 1'b0;
      touch        = 1'b0;
      state_d      = ST_IDLE;
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_OFF;
      tgt_q        <= '0;
      is_on_q      <= 1'b0;
      ev_note_q    <= '0;
      ev_vel_q     <= '0;
      note_on_q    <= '0;
      voice_note_q <= '0;
      voice_vel_q  <= '0;
      steal_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      tgt_q        <= tgt_d;
      is_on_q      <= is_on_d;
      ev_note_q    <= ev_note_d;
      ev_vel_q     <= ev_vel_d;
      note_on_q    <= note_on_d;
      voice_note_q <= voice_note_d;
      voice_vel_q  <= voice_vel_d;
      steal_q      <= steal_d;
      ready_q      <= ready_d;
    end
  end

  assign ev_ready       = ready_q;
  assign note_on        = note_on_q;
  assign voice_note     = voice_note_q;
  assign voice_velocity = voice_vel_q;
  assign steal_pulse    = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator against a slot/age-list reference model.
module tb_voice_allocator;

  localparam int unsigned N  = 8;
  localparam int unsigned NW = 7;
  localparam int unsigned VW = 7;

  localparam int K_OFF    = 0;
  localparam int K_FREE   = 1;
  localparam int K_RETRIG = 2;
  localparam int K_STEAL  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ev_valid;
  logic            ev_ready;
  logic            ev_on;
  logic [NW-1:0]   ev_note;
  logic [VW-1:0]   ev_velocity;
  logic            all_notes_off;
  logic [N-1:0]    note_on;
  logic [N*NW-1:0] voice_note;
  logic [N*VW-1:0] voice_velocity;
  logic            steal_pulse;

  voice_allocator #(
    .NUM_VOICES (N),
    .NOTE_WIDTH (NW),
    .VEL_WIDTH  (VW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_note        (ev_note),
    .ev_velocity    (ev_velocity),
    .all_notes_off  (all_notes_off),
    .note_on        (note_on),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .steal_pulse    (steal_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-slot gate/note/velocity, age list with oldest at the front.
  logic [N-1:0]  m_gate;
  logic [NW-1:0] m_note [N];
  logic [VW-1:0] m_vel  [N];
  int            age_q [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_notes();
    logic [N*NW-1:0] r;
    for (int v = 0; v < N; v++) r[v*NW +: NW] = m_note[v];
    return 64'(r);
  endfunction

  function automatic logic [63:0] pack_vels();
    logic [N*VW-1:0] r;
    for (int v = 0; v < N; v++) r[v*VW +: VW] = m_vel[v];
    return 64'(r);
  endfunction

  function automatic void model_reset();
    m_gate = '0;
    age_q.delete();
    for (int v = 0; v < N; v++) begin
      m_note[v] = '0;
      m_vel[v]  = '0;
      age_q.push_back(v);
    end
  endfunction

  function automatic void allocate(input int t, input logic [NW-1:0] n, input logic [VW-1:0] vel);
    m_gate[t] = 1'b1;
    m_note[t] = n;
    m_vel[t]  = vel;
    for (int i = 0; i < age_q.size(); i++) begin
      if (age_q[i] == t) begin
        age_q.delete(i);
        break;
      end
    end
    age_q.push_back(t);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_gate"}, 64'(note_on), 64'(m_gate));
    chk({tag, "_note"}, 64'(voice_note), pack_notes());
    chk({tag, "_vel"},  64'(voice_velocity), pack_vels());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gate",  64'(note_on), 64'd0);
    chk("rst_note",  64'(voice_note), 64'd0);
    chk("rst_vel",   64'(voice_velocity), 64'd0);
    chk("rst_ready", 64'(ev_ready), 64'd1);
    chk("rst_steal", 64'(steal_pulse), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_event(input bit on, input logic [NW-1:0] n, input logic [VW-1:0] vel);
    bit           is_on;
    int           kind;
    int           tgt;
    logic [N-1:0] g;
    is_on = on && (vel != 0);
    tgt   = -1;
    kind  = K_OFF;
    if (is_on) begin
      for (int v = 0; v < N; v++) if (tgt < 0 && m_gate[v] && m_note[v] == n) tgt = v;
      if (tgt >= 0) kind = K_RETRIG;
      else begin
        for (int v = 0; v < N; v++) if (tgt < 0 && !m_gate[v]) tgt = v;
        if (tgt >= 0) kind = K_FREE;
        else begin
          kind = K_STEAL;
          tgt  = age_q[0];
        end
      end
    end

    chk("ready_idle", 64'(ev_ready), 64'd1);
    ev_valid = 1'b1; ev_on = on; ev_note = n; ev_velocity = vel;
    @(posedge clk); #1;
    ev_valid = 1'b0; ev_on = 1'($urandom); ev_note = NW'($urandom); ev_velocity = VW'($urandom);
    chk("ready_busy", 64'(ev_ready), 64'd0);
    chk("gate_e0", 64'(note_on), 64'(m_gate));
    @(posedge clk); #1;
    chk("gate_e1", 64'(note_on), 64'(m_gate));
    @(posedge clk); #1;
    if (kind == K_OFF) begin
      for (int v = 0; v < N; v++) if (m_gate[v] && m_note[v] == n) m_gate[v] = 1'b0;
    end else if (kind == K_FREE) begin
      allocate(tgt, n, vel);
    end else begin
      g = m_gate;
      g[tgt] = 1'b0;
      chk("gate_gap", 64'(note_on), 64'(g));
      chk("ready_gap", 64'(ev_ready), 64'd0);
      chk("steal_early", 64'(steal_pulse), 64'd0);
      @(posedge clk); #1;
      allocate(tgt, n, vel);
    end
    check_state("commit");
    chk("steal_pulse", 64'(steal_pulse), 64'(kind == K_STEAL));
    chk("ready_after", 64'(ev_ready), 64'd1);
    @(posedge clk); #1;
    chk("steal_clear", 64'(steal_pulse), 64'd0);
  endtask

  task automatic panic_idle(input bit with_event);
    ev_valid = with_event; ev_on = 1'b1; ev_note = NW'($urandom); ev_velocity = 7'd50;
    all_notes_off = 1'b1;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    all_notes_off = 1'b0;
    m_gate = '0;
    chk("panic_ready", 64'(ev_ready), 64'd1);
    check_state("panic");
    repeat (3) @(posedge clk);
    #1;
    check_state("panic_later");
    chk("panic_steal", 64'(steal_pulse), 64'd0);
  endtask

  task automatic panic_in_search(input logic [NW-1:0] n);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = n; ev_velocity = 7'd80;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    chk("psearch_busy", 64'(ev_ready), 64'd0);
    all_notes_off = 1'b1;
    @(posedge clk); #1;
    all_notes_off = 1'b0;
    m_gate = '0;
    chk("psearch_gate", 64'(note_on), 64'd0);
    chk("psearch_ready", 64'(ev_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_state("psearch_later");
    chk("psearch_steal", 64'(steal_pulse), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_velocity = '0;
    all_notes_off = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two free allocations.
    send_event(1'b1, 7'd60, 7'd100);
    send_event(1'b1, 7'd64, 7'd90);
    chk("free_v0_note", 64'(voice_note[NW-1:0]), 64'd60);
    chk("free_v1_note", 64'(voice_note[2*NW-1:NW]), 64'd64);
    chk("free_gates", 64'(note_on), 64'h3);

    // Fill all voices, then steal the oldest.
    do_reset();
    for (int i = 0; i < N; i++) send_event(1'b1, NW'(60 + i), 7'd100);
    send_event(1'b1, 7'd72, 7'd77);
    chk("steal_v0_note", 64'(voice_note[NW-1:0]), 64'd72);
    chk("steal_gates", 64'(note_on), 64'hff);

    // Retrigger of a held note.
    do_reset();
    send_event(1'b1, 7'd60, 7'd100);
    send_event(1'b1, 7'd60, 7'd20);
    chk("retrig_gates", 64'(note_on), 64'h1);

    // Note-off, zero-velocity note-on as off, then reuse of freed slot.
    do_reset();
    for (int i = 0; i < 3; i++) send_event(1'b1, NW'(60 + i), 7'd100);
    send_event(1'b0, 7'd61, 7'd33);
    chk("off_gates", 64'(note_on), 64'h5);
    send_event(1'b1, 7'd62, 7'd0);
    chk("vel0_gates", 64'(note_on), 64'h1);
    send_event(1'b1, 7'd70, 7'd45);
    chk("reuse_gates", 64'(note_on), 64'h3);
    chk("reuse_v1_note", 64'(voice_note[2*NW-1:NW]), 64'd70);
    send_event(1'b0, 7'd99, 7'd10);

    // Panic during SEARCH, and panic racing an arriving event.
    panic_in_search(7'd65);
    for (int i = 0; i < 4; i++) send_event(1'b1, NW'(40 + i), 7'd10);
    panic_idle(1'b1);

    // Reset in the middle of an event.
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd90; ev_velocity = 7'd90;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();
    send_event(1'b1, 7'd91, 7'd5);
    chk("post_rst_gates", 64'(note_on), 64'h1);

    // Random traffic over a narrow note range to force retriggers and steals.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        panic_idle(1'($urandom_range(0, 1)));
      end else begin
        send_event(($urandom_range(0, 3) != 0),
                   NW'(60 + $urandom_range(0, 11)),
                   ($urandom_range(0, 7) == 0) ? 7'd0 : VW'($urandom_range(1, 127)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
